dda_sequencer: RTL and testbench
================================

DDA_SEQUENCER -- requirements
Module: dda_sequencer

Interface
REQ-001 Parameter N, default 16, posit word width of the sampled state variables.
REQ-002 Parameter SW, default 16, width of step count and sample index.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of a run in progress.
REQ-007 steps  input  SW  total Euler steps per run; captured on start acceptance.
REQ-008 decim  input  8  steps between emitted samples; 0 treated as 1; captured on start acceptance.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse at normal run completion.
REQ-011 dda_en  output  1  integrator enable to the solver.
REQ-012 dda_load_n  output  1  solver reset, active-low, effective only with dda_en=1; loads initial conditions.
REQ-013 dda_v1, dda_v2  input  N each  solver state variables, registered in the solver.
REQ-014 out_v1, out_v2  output  N each  sample data, driven directly from dda_v1/dda_v2.
REQ-015 out_idx  output  SW  step index of the presented sample.
REQ-016 out_valid / out_ready  output / input  1 each  sample handshake; transfer when both high on a rising edge.

Function
REQ-017 States: IDLE, LOAD, EMIT, RUN, DONE.
REQ-018 IDLE: start=1 and abort=0 -> LOAD; capture steps and decim (0->1); clear step_cnt and sub_cnt.
REQ-019 LOAD: exactly one cycle; dda_en=1, dda_load_n=0; -> EMIT.
REQ-020 EMIT: dda_en=0; out_valid=1; out_idx=step_cnt; solver frozen, so out_v1/out_v2 are stable while out_valid is high.
REQ-021 EMIT with out_ready=1: step_cnt==steps -> DONE; otherwise -> RUN, clearing sub_cnt.
REQ-022 EMIT with out_ready=0: remain in EMIT; no solver step (backpressure stalls integration).
REQ-023 RUN: dda_en=1, dda_load_n=1; each cycle increments step_cnt and sub_cnt (one Euler step).
REQ-024 RUN exit: after the increment, if sub_cnt==decim or step_cnt==steps -> EMIT; else stay in RUN.
REQ-025 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-026 Samples per run: 1 + ceil(steps/decim). The first sample is the initial condition with out_idx=0; the last sample has out_idx=steps.
REQ-027 steps=0: LOAD, then one EMIT with out_idx=0, then DONE.
REQ-028 Latency: start accepted at edge T -> LOAD during cycle T+1, out_valid high from cycle T+2.
REQ-029 Minimum steps-to-sample latency: decim RUN cycles after a handshake when out_ready is held high.
REQ-030 start while busy is ignored; steps and decim are not re-captured.
REQ-031 abort=1 in any non-IDLE state -> IDLE at next edge; dda_en=0 and out_valid=0 from that cycle; no done pulse.
REQ-032 abort=1 together with start in IDLE: abort wins; remain in IDLE.
REQ-033 abort and out_ready together in EMIT: the handshake still completes that edge; the state becomes IDLE.
REQ-034 Counters do not wrap: step_cnt never exceeds steps (SW bits); sub_cnt never exceeds decim (8 bits).
REQ-035 dda_load_n=1 in every state except LOAD.

Reset
REQ-036 rst_n=0 at a rising edge: state=IDLE; step_cnt, sub_cnt, captured steps/decim = 0.
REQ-037 Outputs during and after reset: busy=0, done=0, dda_en=0, dda_load_n=1, out_valid=0, out_idx=0.
REQ-038 Reset mid-run has the same effect as abort, overriding all other inputs; no done pulse.

Verification
REQ-039 steps=4, decim=2, out_ready=1 -> samples at out_idx 0, 2, 4; dda_en high for 1 (LOAD) + 4 (RUN) cycles; done pulses once; busy falls the cycle after done.
REQ-040 steps=5, decim=2 -> out_idx 0, 2, 4, 5 (final partial interval emitted); 4 samples total.
REQ-041 steps=3, decim=0 -> decim treated as 1; out_idx 0, 1, 2, 3.
REQ-042 steps=4, decim=1, out_ready held low 10 cycles at out_idx=2 -> out_valid, out_idx and out_v1/out_v2 stable; dda_en=0 throughout; resumes on out_ready=1.
REQ-043 abort asserted in RUN at step_cnt=3 of steps=8 -> next cycle busy=0, dda_en=0, out_valid=0; no done; a fresh start then reloads (LOAD seen, first out_idx=0).
REQ-044 steps=0 -> exactly one sample (out_idx=0) then done; start pulsed during EMIT is ignored.

Source files
------------

// File: rtl/dda_sequencer.sv
// rtl/dda_sequencer.sv - run sequencer that steps a DDA solver and emits decimated samples
module dda_sequencer #(
  parameter int N  = 16,
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [SW-1:0] steps,
  input  logic [7:0]    decim,
  output logic          busy,
  output logic          done,
  output logic          dda_en,
  output logic          dda_load_n,
  input  logic [N-1:0]  dda_v1,
  input  logic [N-1:0]  dda_v2,
  output logic [N-1:0]  out_v1,
  output logic [N-1:0]  out_v2,
  output logic [SW-1:0] out_idx,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT,
    S_RUN,
    S_DONE
  } state_t;

  // Output bundle order: {busy, done, dda_en, dda_load_n, out_valid}
  function automatic logic [4:0] outs_of(input state_t s);
    case (s)
      S_LOAD:  outs_of = 5'b10100;
      S_EMIT:  outs_of = 5'b10011;
      S_RUN:   outs_of = 5'b10110;
      S_DONE:  outs_of = 5'b11010;
      default: outs_of = 5'b00010;
    endcase
  endfunction

  state_t        r_state;
  logic [4:0]    r_outs;
  logic [SW-1:0] r_steps;
  logic [SW-1:0] r_step_cnt;
  logic [7:0]    r_decim;
  logic [7:0]    r_sub_cnt;

  logic [SW-1:0] w_step_inc;
  logic [7:0]    w_sub_inc;

  assign w_step_inc = r_step_cnt + SW'(1);
  assign w_sub_inc  = r_sub_cnt + 8'd1;

  assign busy       = r_outs[4];
  assign done       = r_outs[3];
  assign dda_en     = r_outs[2];
  assign dda_load_n = r_outs[1];
  assign out_valid  = r_outs[0];

  // The solver is frozen whenever a sample is presented, so its state feeds the sample port directly
  assign out_v1  = dda_v1;
  assign out_v2  = dda_v2;
  assign out_idx = r_step_cnt;

  // Run sequencing: state, step/decimation counters and registered control outputs move together
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_outs     <= outs_of(S_IDLE);
      r_steps    <= '0;
      r_decim    <= '0;
      r_step_cnt <= '0;
      r_sub_cnt  <= '0;
    end else if (abort && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
      r_outs  <= outs_of(S_IDLE);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_steps    <= steps;
            r_decim    <= (decim == 8'd0) ? 8'd1 : decim;
            r_step_cnt <= '0;
            r_sub_cnt  <= '0;
            r_state    <= S_LOAD;
            r_outs     <= outs_of(S_LOAD);
          end
        end
        S_LOAD: begin
          r_state <= S_EMIT;
          r_outs  <= outs_of(S_EMIT);
        end
        S_EMIT: begin
          // Without out_ready the solver stays frozen, stalling integration
          if (out_ready) begin
            if (r_step_cnt == r_steps) begin
              r_state <= S_DONE;
              r_outs  <= outs_of(S_DONE);
            end else begin
              r_sub_cnt <= '0;
              r_state   <= S_RUN;
              r_outs    <= outs_of(S_RUN);
            end
          end
        end
        S_RUN: begin
          // One Euler step per cycle; the last interval may be shorter than decim
          r_step_cnt <= w_step_inc;
          r_sub_cnt  <= w_sub_inc;
          if ((w_sub_inc == r_decim) || (w_step_inc == r_steps)) begin
            r_state <= S_EMIT;
            r_outs  <= outs_of(S_EMIT);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_outs  <= outs_of(S_IDLE);
        end
        default: begin
          r_state <= S_IDLE;
          r_outs  <= outs_of(S_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dda_sequencer.sv
// tb/tb_dda_sequencer.sv - randomized self-checking bench for dda_sequencer
module tb_dda_sequencer;
  localparam int N  = 16;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] steps = '0;
  logic [7:0]    decim = '0;
  logic          out_ready = 1'b0;
  logic          busy, done, dda_en, dda_load_n, out_valid;
  logic [N-1:0]  dda_v1 = '0;
  logic [N-1:0]  dda_v2 = '0;
  logic [N-1:0]  out_v1, out_v2;
  logic [SW-1:0] out_idx;

  logic [N-1:0]  init1, init2, inc1, inc2;
  int            hold_idx = -1;
  int            total = 0;
  int            bad = 0;

  dda_sequencer #(.N(N), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .steps(steps), .decim(decim),
    .busy(busy), .done(done), .dda_en(dda_en), .dda_load_n(dda_load_n),
    .dda_v1(dda_v1), .dda_v2(dda_v2),
    .out_v1(out_v1), .out_v2(out_v2), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Stand-in solver: loads initial conditions, then one linear step per enabled cycle
  always @(posedge clk) begin
    if (dda_en) begin
      if (!dda_load_n) begin
        dda_v1 <= init1;
        dda_v2 <= init2;
      end else begin
        dda_v1 <= dda_v1 + inc1;
        dda_v2 <= dda_v2 - inc2;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode: 0 normal, 1 abort, 2 reset; stop_at = step_cnt of the RUN cycle to cancel in
  task automatic run(input int st, input int dc, input int pct, input int mode, input int stop_at);
    int d, i, n, runs, gap, holds, cyc;
    int q[$];
    bit fin, done_seen, stalled;
    logic [N-1:0] e1, e2;
    d = (dc == 0) ? 1 : dc;
    q.delete();
    q.push_back(0);
    i = 0;
    while (i < st) begin
      i = (i + d > st) ? st : i + d;
      q.push_back(i);
    end
    init1 = N'($urandom); init2 = N'($urandom);
    inc1  = N'($urandom); inc2  = N'($urandom);
    n = 0; runs = 0; gap = 0; holds = 0; cyc = 0;
    fin = 0; done_seen = 0; stalled = 0;

    @(negedge clk);
    start = 1'b1; steps = SW'(st); decim = 8'(dc); out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("load_en", dda_en, 1);
    chk("load_n", dda_load_n, 0);
    chk("load_busy", busy, 1);
    chk("load_valid", out_valid, 0);

    while (!fin && cyc < 4000) begin
      cyc++;
      @(negedge clk);
      if (done_seen) begin
        start = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_en", dda_en, 0);
        chk("idle_done", done, 0);
        fin = 1;
        continue;
      end
      if (mode != 0 && dda_en && dda_load_n && runs == stop_at) begin
        if (mode == 1) abort = 1'b1;
        else rst_n = 1'b0;
        start = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("cancel_busy", busy, 0);
        chk("cancel_en", dda_en, 0);
        chk("cancel_valid", out_valid, 0);
        chk("cancel_done", done, 0);
        chk("cancel_load_n", dda_load_n, 1);
        if (mode == 2) chk("rst_idx", out_idx, 0);
        rst_n = 1'b1; abort = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("abort_wins", busy, 0);
        abort = 1'b0; start = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("no_done", done, 0);
          chk("stay_idle", busy, 0);
        end
        fin = 1;
        continue;
      end
      chk("load_n_high", dda_load_n, 1);
      chk("busy_run", busy, 1);
      if (done) begin
        done_seen = 1;
        chk("done_samples", n, q.size());
        chk("done_steps", runs, st);
        chk("done_valid", out_valid, 0);
      end
      if (out_valid) begin
        chk("valid_en", dda_en, 0);
        if (n < q.size()) begin
          e1 = init1 + N'(q[n]) * inc1;
          e2 = init2 - N'(q[n]) * inc2;
          chk("idx", out_idx, q[n]);
          chk("v1", out_v1, e1);
          chk("v2", out_v2, e2);
          if (!stalled) chk("gap", gap, (n == 0) ? 0 : q[n] - q[n-1]);
        end else begin
          chk("extra_sample", n, q.size() - 1);
        end
      end
      if (dda_en) begin
        runs++;
        gap++;
      end
      start = 1'($urandom_range(0, 3) == 0);
      steps = SW'($urandom);
      decim = 8'($urandom);
      if (out_valid && int'(out_idx) == hold_idx && holds < 10) begin
        out_ready = 1'b0;
        holds++;
      end else begin
        out_ready = 1'($urandom_range(0, 99) < pct);
      end
      if (out_valid && out_ready) begin
        n++;
        gap = 0;
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    int st, dc, md, sa;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", dda_en, 0);
    chk("rst_load_n", dda_load_n, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_idx0", out_idx, 0);
    rst_n = 1'b1;

    run(4, 2, 100, 0, 0);
    run(5, 2, 100, 0, 0);
    run(3, 0, 100, 0, 0);
    hold_idx = 2;
    run(4, 1, 100, 0, 0);
    hold_idx = -1;
    run(8, 1, 100, 1, 3);
    run(0, 5, 100, 0, 0);
    run(6, 3, 100, 2, 2);
    run(3, 255, 60, 0, 0);

    for (int k = 0; k < 20; k++) begin
      st = $urandom_range(0, 40);
      dc = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 12);
      md = (st > 0) ? $urandom_range(0, 2) : 0;
      if (md == 2 && $urandom_range(0, 1) == 0) md = 0;
      sa = (st > 0) ? $urandom_range(0, st - 1) : 0;
      run(st, dc, $urandom_range(20, 100), md, sa);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
